// File: rtl/dtree_pkg.sv
// Shared types and width helpers for the node-serial decision-tree engine.
// Node word, MSB first: leaf | fidx | shift | thr | left | right.
package dtree_pkg;

    localparam int unsigned FLD_W      = 32;
    localparam int unsigned NODE_MAX_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        F_RIGHT = 3'd0,
        F_LEFT  = 3'd1,
        F_THR   = 3'd2,
        F_SHIFT = 3'd3,
        F_FIDX  = 3'd4,
        F_LEAF  = 3'd5
    } node_field_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned nidx_w(input int unsigned n_nodes);
        return clog2_min1(n_nodes);
    endfunction

    function automatic int unsigned node_w(input int unsigned n_feat,
                                           input int unsigned feat_w,
                                           input int unsigned n_nodes);
        return 1 + clog2_min1(n_feat) + clog2_min1(feat_w) + feat_w + 2 * nidx_w(n_nodes);
    endfunction

    // Extract one field of a node word; widths are elaboration-time constants.
    function automatic logic [FLD_W-1:0] node_field(input logic [NODE_MAX_W-1:0] word,
                                                   input node_field_t   fld,
                                                   input int unsigned   n_feat,
                                                   input int unsigned   feat_w,
                                                   input int unsigned   n_nodes);
        int unsigned nw;
        int unsigned off;
        int unsigned w;
        logic [NODE_MAX_W-1:0] mask;
        nw  = nidx_w(n_nodes);
        off = 0;
        w   = nw;
        case (fld)
            F_RIGHT: begin off = 0;        w = nw;     end
            F_LEFT:  begin off = nw;       w = nw;     end
            F_THR:   begin off = 2 * nw;   w = feat_w; end
            F_SHIFT: begin off = 2 * nw + feat_w; w = clog2_min1(feat_w); end
            F_FIDX:  begin
                off = 2 * nw + feat_w + clog2_min1(feat_w);
                w   = clog2_min1(n_feat);
            end
            default: begin off = node_w(n_feat, feat_w, n_nodes) - 1; w = 1; end
        endcase
        mask = (NODE_MAX_W'(1) << w) - NODE_MAX_W'(1);
        return FLD_W'((word >> off) & mask);
    endfunction

endpackage

// File: rtl/dtree_node_eval.sv
// Combinational evaluation of one internal node: feature select, shift, compare,
// child select and child range check. go_right_c exists only with DTREE_PATH_EN.
module dtree_node_eval
    import dtree_pkg::*;
#(
    parameter int unsigned N_FEAT  = 64,
    parameter int unsigned FEAT_W  = 8,
    parameter int unsigned N_NODES = 64,
    localparam int unsigned FIDX_W  = clog2_min1(N_FEAT),
    localparam int unsigned SHIFT_W = clog2_min1(FEAT_W),
    localparam int unsigned NIDX_W  = nidx_w(N_NODES)
) (
`ifdef DTREE_PATH_EN
    output logic                     go_right_c,
`endif
    input  logic [N_FEAT*FEAT_W-1:0] feat,
    input  logic [FIDX_W-1:0]        fidx,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic [FEAT_W-1:0]        thr,
    input  logic [NIDX_W-1:0]        left,
    input  logic [NIDX_W-1:0]        right,
    output logic [NIDX_W-1:0]        child_c,
    output logic                     child_bad_c
);

    logic [FEAT_W-1:0] feat_arr [N_FEAT];
    logic [FEAT_W-1:0] sel;
    logic [FEAT_W-1:0] shifted;
    logic              go_right;

    for (genvar i = 0; i < N_FEAT; i++) begin : g_unpack
        assign feat_arr[i] = feat[i*FEAT_W +: FEAT_W];
    end

    // MSB-slice compare: true keeps the left child.
    always_comb begin
        sel = '0;
        if (32'(fidx) < N_FEAT) sel = feat_arr[fidx];
        shifted     = sel >> shift;
        go_right    = !(shifted <= thr);
        child_c     = go_right ? right : left;
        child_bad_c = 32'(child_c) >= N_NODES;
    end

`ifdef DTREE_PATH_EN
    assign go_right_c = go_right;
`endif

endmodule

// File: rtl/dtree_seq_engine.sv
// Node-serial decision-tree classifier: one node per clock from a writable node table.
// Optional DTREE_PATH_EN adds out_path, the left/right decision per depth.
module dtree_seq_engine
    import dtree_pkg::*;
#(
    parameter int unsigned N_FEAT    = 64,
    parameter int unsigned FEAT_W    = 8,
    parameter int unsigned CLASS_W   = 5,
    parameter int unsigned N_NODES   = 64,
    parameter int unsigned MAX_DEPTH = 16,
    localparam int unsigned NIDX_W   = nidx_w(N_NODES),
    localparam int unsigned NODE_W   = node_w(N_FEAT, FEAT_W, N_NODES),
    localparam int unsigned DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_feat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     out_err,
    output logic [DEPTH_W-1:0]       out_depth,
`ifdef DTREE_PATH_EN
    output logic [MAX_DEPTH-1:0]     out_path,
`endif
    input  logic                     cfg_we,
    input  logic [NIDX_W-1:0]        cfg_addr,
    input  logic [NODE_W-1:0]        cfg_data,
    output logic                     cfg_ready
);

    localparam int unsigned FIDX_W  = clog2_min1(N_FEAT);
    localparam int unsigned SHIFT_W = clog2_min1(FEAT_W);

    state_t                     state_q, state_d;
    logic [NODE_W-1:0]          node_tbl [N_NODES];
    logic [N_FEAT*FEAT_W-1:0]   feat_q, feat_d;
    logic [NIDX_W-1:0]          idx_q, idx_d;
    logic [DEPTH_W-1:0]         depth_q, depth_d;
    logic                       out_valid_d;
    logic [CLASS_W-1:0]         out_class_d;
    logic                       out_err_d;
    logic [DEPTH_W-1:0]         out_depth_d;
    logic                       tbl_we_c;

    logic [NODE_W-1:0]          node_c;
    logic                       leaf_c;
    logic [NIDX_W-1:0]          child_c;
    logic                       child_bad_c;

`ifdef DTREE_PATH_EN
    logic [MAX_DEPTH-1:0]       path_q, path_d;
    logic [MAX_DEPTH-1:0]       out_path_d;
    logic                       go_right_c;
`endif

    assign node_c = node_tbl[idx_q];
    assign leaf_c = 1'(node_field(NODE_MAX_W'(node_c), F_LEAF, N_FEAT, FEAT_W, N_NODES));

    dtree_node_eval #(
        .N_FEAT  (N_FEAT),
        .FEAT_W  (FEAT_W),
        .N_NODES (N_NODES)
    ) u_eval (
`ifdef DTREE_PATH_EN
        .go_right_c  (go_right_c),
`endif
        .feat        (feat_q),
        .fidx        (FIDX_W'(node_field(NODE_MAX_W'(node_c), F_FIDX, N_FEAT, FEAT_W, N_NODES))),
        .shift       (SHIFT_W'(node_field(NODE_MAX_W'(node_c), F_SHIFT, N_FEAT, FEAT_W, N_NODES))),
        .thr         (FEAT_W'(node_field(NODE_MAX_W'(node_c), F_THR, N_FEAT, FEAT_W, N_NODES))),
        .left        (NIDX_W'(node_field(NODE_MAX_W'(node_c), F_LEFT, N_FEAT, FEAT_W, N_NODES))),
        .right       (NIDX_W'(node_field(NODE_MAX_W'(node_c), F_RIGHT, N_FEAT, FEAT_W, N_NODES))),
        .child_c     (child_c),
        .child_bad_c (child_bad_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        feat_d      = feat_q;
        idx_d       = idx_q;
        depth_d     = depth_q;
        out_valid_d = out_valid;
        out_class_d = out_class;
        out_err_d   = out_err;
        out_depth_d = out_depth;
        tbl_we_c    = 1'b0;
`ifdef DTREE_PATH_EN
        path_d      = path_q;
        out_path_d  = out_path;
`endif
        case (state_q)
            ST_IDLE: begin
                tbl_we_c = cfg_we;
                if (in_valid) begin
                    feat_d  = in_feat;
                    idx_d   = '0;
                    depth_d = '0;
`ifdef DTREE_PATH_EN
                    path_d  = '0;
`endif
                    state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                if (leaf_c) begin
                    out_class_d = CLASS_W'(node_c);
                    out_err_d   = 1'b0;
                    out_depth_d = depth_q;
                    out_valid_d = 1'b1;
`ifdef DTREE_PATH_EN
                    out_path_d  = path_q;
`endif
                    state_d     = ST_DONE;
                end else if (depth_q == DEPTH_W'(MAX_DEPTH) || child_bad_c) begin
                    out_class_d = '0;
                    out_err_d   = 1'b1;
                    out_depth_d = depth_q;
                    out_valid_d = 1'b1;
`ifdef DTREE_PATH_EN
                    out_path_d  = path_q;
`endif
                    state_d     = ST_DONE;
                end else begin
                    idx_d   = child_c;
                    depth_d = depth_q + DEPTH_W'(1);
`ifdef DTREE_PATH_EN
                    path_d  = path_q | (MAX_DEPTH'(go_right_c) << depth_q);
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; ready flags follow the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            feat_q    <= '0;
            idx_q     <= '0;
            depth_q   <= '0;
            in_ready  <= 1'b1;
            cfg_ready <= 1'b1;
            out_valid <= 1'b0;
            out_class <= '0;
            out_err   <= 1'b0;
            out_depth <= '0;
`ifdef DTREE_PATH_EN
            path_q    <= '0;
            out_path  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            feat_q    <= feat_d;
            idx_q     <= idx_d;
            depth_q   <= depth_d;
            in_ready  <= (state_d == ST_IDLE);
            cfg_ready <= (state_d == ST_IDLE);
            out_valid <= out_valid_d;
            out_class <= out_class_d;
            out_err   <= out_err_d;
            out_depth <= out_depth_d;
`ifdef DTREE_PATH_EN
            path_q    <= path_d;
            out_path  <= out_path_d;
`endif
        end
    end

    // Node table: cleared by reset, so an unprogrammed root self-loops into a depth fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) node_tbl[i] <= '0;
        end else if (tbl_we_c && (32'(cfg_addr) < N_NODES)) begin
            node_tbl[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Scoreboard bench for dtree_seq_engine: randomized trees and samples checked against
// a tree-walk reference model, plus a 48-node instance for out-of-range children.
module tb_dtree_seq_engine;

    localparam int N_FEAT    = 64;
    localparam int FEAT_W    = 8;
    localparam int CLASS_W   = 5;
    localparam int N_NODES   = 64;
    localparam int MAX_DEPTH = 16;
    localparam int NIDX_W    = 6;
    localparam int NODE_W    = 30;
    localparam int DEPTH_W   = 5;
    localparam int FW        = N_FEAT * FEAT_W;

    logic               clk, rst_n;
    logic               in_valid, in_ready;
    logic [FW-1:0]      in_feat;
    logic               out_valid, out_ready;
    logic [CLASS_W-1:0] out_class;
    logic               out_err;
    logic [DEPTH_W-1:0] out_depth;
    logic               cfg_we, cfg_ready;
    logic [NIDX_W-1:0]  cfg_addr;
    logic [NODE_W-1:0]  cfg_data;

    logic               in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [CLASS_W-1:0] out_class_b;
    logic               out_err_b;
    logic [DEPTH_W-1:0] out_depth_b;
    logic               cfg_we_b, cfg_ready_b;
`ifdef DTREE_PATH_EN
    logic [MAX_DEPTH-1:0] out_path, out_path_b;
`endif

    dtree_seq_engine u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_err(out_err), .out_depth(out_depth),
`ifdef DTREE_PATH_EN
        .out_path(out_path),
`endif
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready)
    );

    dtree_seq_engine #(.N_NODES(48)) u_dut48 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_feat(in_feat),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_class(out_class_b),
        .out_err(out_err_b), .out_depth(out_depth_b),
`ifdef DTREE_PATH_EN
        .out_path(out_path_b),
`endif
        .cfg_we(cfg_we_b), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference tree: plain per-node field arrays.
    int m_leaf [N_NODES];
    int m_fidx [N_NODES];
    int m_shift[N_NODES];
    int m_thr  [N_NODES];
    int m_left [N_NODES];
    int m_right[N_NODES];
    int m_cls  [N_NODES];

    task automatic model_clear();
        for (int i = 0; i < N_NODES; i++) begin
            m_leaf[i] = 0; m_fidx[i] = 0; m_shift[i] = 0; m_thr[i] = 0;
            m_left[i] = 0; m_right[i] = 0; m_cls[i] = 0;
        end
    endtask

    function automatic void model_walk(input logic [FW-1:0] f, output int cls, output int err,
                                       output int dep, output int path);
        int idx;
        bit done;
        idx = 0; dep = 0; cls = 0; err = 0; path = 0; done = 0;
        for (int step = 0; step <= MAX_DEPTH && !done; step++) begin
            if (m_leaf[idx] != 0) begin
                cls = m_cls[idx];
                done = 1;
            end else if (dep == MAX_DEPTH) begin
                err = 1;
                done = 1;
            end else begin
                int v;
                int nxt;
                bit rgt;
                v   = int'(f[m_fidx[idx]*FEAT_W +: FEAT_W]) >> m_shift[idx];
                rgt = (v > m_thr[idx]);
                nxt = rgt ? m_right[idx] : m_left[idx];
                if (nxt >= N_NODES) begin
                    err = 1;
                    done = 1;
                end else begin
                    if (rgt) path = path | (1 << dep);
                    idx = nxt;
                    dep++;
                end
            end
        end
    endfunction

    typedef struct {
        int cls;
        int err;
        int dep;
        int path;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   prev_ov = 0;
    int   rise_cyc = 0;
    int   snap_class, snap_err, snap_depth;

    // Monitor: records expectations on accept, compares on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 0;
        end else begin
            if (in_valid && in_ready) begin
                model_walk(in_feat, mon_e.cls, mon_e.err, mon_e.dep, mon_e.path);
                mon_e.acc = cyc;
                sb.push_back(mon_e);
            end
            if (out_valid && !prev_ov) begin
                rise_cyc   = cyc;
                snap_class = int'(out_class);
                snap_err   = int'(out_err);
                snap_depth = int'(out_depth);
            end else if (out_valid) begin
                check("hold_class", int'(out_class), snap_class);
                check("hold_err", int'(out_err), snap_err);
                check("hold_depth", int'(out_depth), snap_depth);
            end
            if (out_valid) check("busy_in_ready", int'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check("class", int'(out_class), mon_e.cls);
                    check("err", int'(out_err), mon_e.err);
                    check("depth", int'(out_depth), mon_e.dep);
                    check("latency", rise_cyc - mon_e.acc, mon_e.dep + 2);
`ifdef DTREE_PATH_EN
                    check("path", int'(out_path), mon_e.path);
`endif
                end
            end
            prev_ov = out_valid;
        end
    end

    bit bp_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    function automatic logic [NODE_W-1:0] build_word(input int leaf, input int fidx, input int shift,
                                                    input int thr, input int left, input int right,
                                                    input int cls);
        logic [NODE_W-1:0] w;
        if (leaf != 0) begin
            w = {1'b1, 29'($urandom)};
            w[CLASS_W-1:0] = CLASS_W'(cls);
        end else begin
            w = {1'b0, 6'(fidx), 3'(shift), 8'(thr), 6'(left), 6'(right)};
        end
        return w;
    endfunction

    task automatic cfg_write(input int addr, input int leaf, input int fidx, input int shift,
                             input int thr, input int left, input int right, input int cls);
        @(posedge clk); #1;
        cfg_addr = NIDX_W'(addr);
        cfg_data = build_word(leaf, fidx, shift, thr, left, right, cls);
        cfg_we   = 1'b1;
        @(negedge clk);
        if (cfg_ready) begin
            m_leaf[addr] = leaf; m_fidx[addr] = fidx; m_shift[addr] = shift; m_thr[addr] = thr;
            m_left[addr] = left; m_right[addr] = right; m_cls[addr] = cls;
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_write_b(input int addr, input logic [NODE_W-1:0] word);
        @(posedge clk); #1;
        cfg_addr = NIDX_W'(addr);
        cfg_data = word;
        cfg_we_b = 1'b1;
        @(posedge clk); #1;
        cfg_we_b = 1'b0;
    endtask

    function automatic logic [FW-1:0] rand_feat();
        logic [FW-1:0] r;
        for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [FW-1:0] feat1(input logic [7:0] v);
        logic [FW-1:0] r;
        r = rand_feat();
        r[1*FEAT_W +: FEAT_W] = v;
        return r;
    endfunction

    task automatic send(input logic [FW-1:0] f);
        int n;
        @(posedge clk); #1;
        in_feat  = f;
        in_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic send_b(input logic [FW-1:0] f, input int e_cls, input int e_err,
                          input int e_dep, input int e_lat);
        int n;
        @(posedge clk); #1;
        in_feat    = f;
        in_valid_b = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready_b) break;
        end
        check("b_accept", int'(in_ready_b), 1);
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        n = 0;
        while (!out_valid_b && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b_valid", int'(out_valid_b), 1);
        check("b_class", int'(out_class_b), e_cls);
        check("b_err", int'(out_err_b), e_err);
        check("b_depth", int'(out_depth_b), e_dep);
        check("b_latency", n, e_lat);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_cfg_ready"}, int'(cfg_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_class"}, int'(out_class), 0);
        check({tag, "_out_err"}, int'(out_err), 0);
        check({tag, "_out_depth"}, int'(out_depth), 0);
    endtask

    task automatic program_tree_a();
        cfg_write(0, 0, 1, 5, 3, 1, 2, 0);
        cfg_write(1, 1, 0, 0, 0, 0, 0, 13);
        cfg_write(2, 1, 0, 0, 0, 0, 0, 2);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_feat = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b1; cfg_we_b = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Unprogrammed table walks into the depth limit.
        send(rand_feat());
        drain(60);

        program_tree_a();
        send(feat1(8'h60));
        drain(20);
        send(feat1(8'h80));
        drain(20);

        // Backpressure: outputs hold, engine busy, config write dropped.
        out_ready = 1'b0;
        send(feat1(8'h60));
        for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
        check("bp_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cfg_addr = NIDX_W'(1);
            cfg_data = build_word(1, 0, 0, 0, 0, 0, 7);
            cfg_we   = (i == 0);
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_cfg_ready", int'(cfg_ready), 0);
        end
        @(posedge clk); #1;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        drain(10);
        send(feat1(8'h60));
        drain(20);

        // Random trees with random backpressure.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N_NODES; i++) begin
                if ($urandom_range(0, 9) < 4)
                    cfg_write(i, 1, 0, 0, 0, 0, 0, int'($urandom_range(0, 31)));
                else
                    cfg_write(i, 0, int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 255)), int'($urandom_range(0, 63)),
                              int'($urandom_range(0, 63)), 0);
            end
            bp_mode = 1;
            for (int s = 0; s < 20; s++) send(rand_feat());
            drain(200);
            bp_mode = 0;
            @(posedge clk); #2;
            out_ready = 1'b1;
        end

        // 48-node instance: child index 48 is out of range.
        cfg_write_b(0, build_word(0, 1, 5, 3, 1, 48, 0));
        cfg_write_b(1, build_word(1, 0, 0, 0, 0, 0, 13));
        send_b(feat1(8'h80), 0, 1, 0, 2);
        send_b(feat1(8'h60), 13, 0, 1, 3);

        // Reset in cycle 2 of a walk.
        program_tree_a();
        send(feat1(8'h60));
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        model_clear();
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(feat1(8'h60));
        drain(60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
